// File: rtl/led_pkg.sv
// Shared encodings for the LED counter controller.
package led_pkg;

   typedef enum logic [1:0] {
      MODE_UP     = 2'b00,
      MODE_DOWN   = 2'b01,
      MODE_BOUNCE = 2'b10,
      MODE_HOLD   = 2'b11
   } mode_t;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

endpackage

// File: rtl/prescaler_tick.sv
// Free-running N-bit prescaler; flags the last count of each period.
module prescaler_tick #(
   parameter int unsigned N = 19
) (
   input  logic CLK,
   input  logic RST,
   input  logic EN,
   input  logic CLR,
   output logic WRAP_NEXT
);

   logic [N-1:0] p;

   // Count enabled cycles; a synchronous clear restarts the period.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         p <= '0;
      end else if (CLR) begin
         p <= '0;
      end else if (EN) begin
         p <= p + N'(1);
      end
   end

   assign WRAP_NEXT = (p == '1);

endmodule

// File: rtl/led_counter_ctrl.sv
// LED display counter: steps up/down/bounce/hold once per prescaler period.
module led_counter_ctrl
   import led_pkg::*;
#(
   parameter int unsigned N = 19,
   parameter int unsigned W = 8
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         EN,
   input  logic [1:0]   MODE,
   input  logic         LOAD,
   input  logic [W-1:0] DATA,
   output logic [W-1:0] LEDS,
   output logic         TICK,
   output logic         WRAP
);

   logic         wrap_next;
   logic [W-1:0] count;
   dir_t         dir;
   logic         tick_q;
   logic         wrap_q;

   // LOAD also clears the prescaler so a load restarts the full period.
   prescaler_tick #(.N(N)) u_prescaler (
      .CLK       (CLK),
      .RST       (RST),
      .EN        (EN),
      .CLR       (LOAD),
      .WRAP_NEXT (wrap_next)
   );

   // Counter, direction and strobe registers; load beats enable beats step.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         count  <= '0;
         dir    <= DIR_UP;
         tick_q <= 1'b0;
         wrap_q <= 1'b0;
      end else if (LOAD) begin
         count  <= DATA;
         tick_q <= 1'b0;
         wrap_q <= 1'b0;
      end else if (!EN || !wrap_next) begin
         tick_q <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         tick_q <= 1'b1;
         wrap_q <= 1'b0;
         case (mode_t'(MODE))
            MODE_UP: begin
               count  <= count + W'(1);
               dir    <= DIR_UP;
               wrap_q <= (count == '1);
            end
            MODE_DOWN: begin
               count  <= count - W'(1);
               dir    <= DIR_DOWN;
               wrap_q <= (count == '0);
            end
            MODE_BOUNCE: begin
               if (dir == DIR_UP) begin
                  if (count == '1) begin
                     count  <= count - W'(1);
                     dir    <= DIR_DOWN;
                     wrap_q <= 1'b1;
                  end else begin
                     count <= count + W'(1);
                  end
               end else begin
                  if (count == '0) begin
                     count  <= W'(1);
                     dir    <= DIR_UP;
                     wrap_q <= 1'b1;
                  end else begin
                     count <= count - W'(1);
                  end
               end
            end
            default: begin
               count <= count;
            end
         endcase
      end
   end

   assign LEDS = count;
   assign TICK = tick_q;
   assign WRAP = wrap_q;

endmodule

// File: tb/tb_led_counter_ctrl.sv
// Self-checking bench: two widths driven in parallel against a reference model.
module tb_led_counter_ctrl;

   localparam int unsigned N = 2;
   localparam int PERIOD = 1 << N;

   logic       clk  = 1'b0;
   logic       rst  = 1'b1;
   logic       en   = 1'b0;
   logic       load = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [3:0] data = 4'h0;

   logic [3:0] leds_a;
   logic       tick_a, wrap_a;
   logic [1:0] leds_b;
   logic       tick_b, wrap_b;

   int n_cmp = 0;
   int n_err = 0;

   // Reference state per instance: [0] is W=4, [1] is W=2.
   int wid[2] = '{4, 2};
   int mc[2], mp[2], mdir[2], mt[2], mw[2];

   always #5 clk = ~clk;

   led_counter_ctrl #(.N(N), .W(4)) dut_a (
      .CLK(clk), .RST(rst), .EN(en), .MODE(mode), .LOAD(load), .DATA(data),
      .LEDS(leds_a), .TICK(tick_a), .WRAP(wrap_a)
   );

   led_counter_ctrl #(.N(N), .W(2)) dut_b (
      .CLK(clk), .RST(rst), .EN(en), .MODE(mode), .LOAD(load), .DATA(data[1:0]),
      .LEDS(leds_b), .TICK(tick_b), .WRAP(wrap_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
      end
   endtask

   function automatic void model_reset();
      for (int k = 0; k < 2; k++) begin
         mc[k] = 0; mp[k] = 0; mdir[k] = 0; mt[k] = 0; mw[k] = 0;
      end
   endfunction

   function automatic void model_step();
      for (int k = 0; k < 2; k++) begin
         int modulus = 1 << wid[k];
         int top = modulus - 1;
         mt[k] = 0;
         mw[k] = 0;
         if (load) begin
            mc[k] = int'(data) % modulus;
            mp[k] = 0;
         end else if (en) begin
            if (mp[k] < PERIOD - 1) begin
               mp[k]++;
            end else begin
               mp[k] = 0;
               mt[k] = 1;
               case (int'(mode))
                  0: begin
                     mw[k] = (mc[k] == top);
                     mc[k] = (mc[k] + 1) % modulus;
                     mdir[k] = 0;
                  end
                  1: begin
                     mw[k] = (mc[k] == 0);
                     mc[k] = (mc[k] + modulus - 1) % modulus;
                     mdir[k] = 1;
                  end
                  2: begin
                     if (mdir[k] == 0 && mc[k] == top) begin
                        mdir[k] = 1; mw[k] = 1;
                     end else if (mdir[k] == 1 && mc[k] == 0) begin
                        mdir[k] = 0; mw[k] = 1;
                     end
                     mc[k] = (mdir[k] == 0) ? mc[k] + 1 : mc[k] - 1;
                  end
                  default: ;
               endcase
            end
         end
      end
   endfunction

   task automatic compare_all();
      check("leds_a", leds_a, mc[0]);
      check("tick_a", tick_a, mt[0]);
      check("wrap_a", wrap_a, mw[0]);
      check("leds_b", leds_b, mc[1]);
      check("tick_b", tick_b, mt[1]);
      check("wrap_b", wrap_b, mw[1]);
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic async_reset();
      #2 rst = 1'b1;
      #1;
      check("areset_leds", leds_a, 0);
      check("areset_tick", tick_a, 0);
      check("areset_wrap", wrap_a, 0);
      model_reset();
      compare_all();
      #1 rst = 1'b0;
   endtask

   task automatic sync_tick();
      int n = 0;
      while (n < 20) begin
         step();
         n++;
         if (tick_a) break;
      end
      check("sync_tick", tick_a, 1);
   endtask

   initial begin
      int wraps, n, ticks;
      logic [3:0] held;
      int bseq[8] = '{1, 2, 3, 2, 1, 0, 1, 2};

      // Reset state
      #12;
      model_reset();
      check("rst_leds", leds_a, 0);
      check("rst_tick", tick_a, 0);
      compare_all();
      rst = 1'b0;
      en = 1'b1;
      mode = 2'b00;

      // Up count: first step on edge 4
      for (int e = 1; e <= 4; e++) begin
         step();
         check("first_step_leds", leds_a, (e == 4) ? 1 : 0);
         check("first_step_tick", tick_a, (e == 4) ? 1 : 0);
      end
      wraps = 0;
      for (int e = 5; e <= 64; e++) begin
         step();
         if (wrap_a) wraps++;
      end
      check("up_wrap_count", wraps, 1);
      check("up_wrap_leds", leds_a, 0);

      // Async reset mid-count, then down mode from zero
      for (int i = 0; i < 6; i++) step();
      async_reset();
      mode = 2'b01;
      for (int e = 1; e <= 4; e++) step();
      check("down_first_leds", leds_a, 15);
      check("down_first_wrap", wrap_a, 1);
      check("down_first_tick", tick_a, 1);
      for (int e = 1; e <= 4; e++) step();
      check("down_second_leds", leds_a, 14);
      check("down_second_wrap", wrap_a, 0);

      // Bounce from reset
      async_reset();
      mode = 2'b10;
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 4; j++) step();
         check("bounce_leds_b", leds_b, bseq[i]);
         check("bounce_wrap_b", wrap_b, (i == 3 || i == 6) ? 1 : 0);
      end

      // Enable gating stretches the period by the disabled cycles
      mode = 2'b00;
      sync_tick();
      step();
      held = leds_a;
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         check("en_frozen", leds_a, held);
      end
      en = 1'b1;
      n = 0;
      while (n < 20) begin
         step();
         n++;
         if (tick_a) break;
      end
      check("en_delay", n, 3);

      // Hold mode keeps ticking but never moves
      mode = 2'b11;
      sync_tick();
      held = leds_a;
      ticks = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (tick_a) ticks++;
         check("hold_leds", leds_a, held);
         check("hold_wrap", wrap_a, 0);
      end
      check("hold_ticks", ticks, 3);

      // Load on the prescaler wrap edge wins
      mode = 2'b00;
      sync_tick();
      for (int i = 0; i < 3; i++) step();
      load = 1'b1;
      data = 4'hA;
      step();
      load = 1'b0;
      check("load_leds", leds_a, 4'hA);
      check("load_tick", tick_a, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("load_no_tick", tick_a, 0);
      end
      step();
      check("load_next_leds", leds_a, 4'hB);
      check("load_next_tick", tick_a, 1);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         en   = ($urandom_range(0, 9) != 0);
         load = ($urandom_range(0, 29) == 0);
         data = 4'($urandom);
         if ($urandom_range(0, 39) == 0) mode = 2'($urandom);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
